// File: rtl/ysyx_22050058_pipe_ctrl_pkg.sv
// Shared definitions for the NPC pipeline controller.
//   - pipe_state_e : redirect-parking FSM encoding (2 bits)
//   - STG_*        : stall/flush bit positions, PC=0 .. WB=5
//   - BR_FLUSH / TRAP_FLUSH : bubble masks for a branch and a trap redirect
//   - stall_upto() : builds a freeze mask covering PC up to a given stage
package ysyx_22050058_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_PEND_BR   = 2'd1,
    ST_PEND_TRAP = 2'd2
  } pipe_state_e;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int NUM_STAGES = STG_WB + 1;

  // A branch resolved in EX kills the two younger instructions (IF, ID);
  // a trap raised in MEM also kills the instructions in EX and MEM itself.
  localparam logic [NUM_STAGES-1:0] BR_FLUSH   = 6'b000110;
  localparam logic [NUM_STAGES-1:0] TRAP_FLUSH = 6'b011110;

  // Mask with every stage from PC through 'last' set. A stage that cannot
  // advance must hold every older stage behind it as well.
  function automatic logic [NUM_STAGES-1:0] stall_upto(input int last);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i <= last);
    end
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22050058_stall_wdt.sv
// Consecutive-stall watchdog.
//   clk, rst      : clock, asynchronous active-low reset
//   stall_pc      : PC freeze (stall[0]) of the current cycle
//   count_o       : current consecutive-stall count (saturating)
//   timeout       : sticky flag, high from the cycle the count reaches
//                   TO_LIMIT until reset
module ysyx_22050058_stall_wdt #(
  parameter int              TO_W     = 16,
  parameter logic [TO_W-1:0] TO_LIMIT = {TO_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_pc,
  output logic [TO_W-1:0] count_o,
  output logic            timeout
);

  logic [TO_W-1:0] count_q, count_d;
  logic            flag_q, flag_d;
  logic            at_limit;

  assign at_limit = (count_q == TO_LIMIT);

  always_comb begin
    count_d = '0;
    flag_d  = flag_q | at_limit;
    if (stall_pc) begin
      count_d = at_limit ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  // The flag is visible in the very cycle the limit is reached; the
  // register keeps it once the stall clears and the count drops to 0.
  assign timeout = flag_q | at_limit;
  assign count_o = count_q;

endmodule

// File: rtl/ysyx_22050058_pipe_ctrl.sv
// Pipeline control for the 6-stage NPC core (PC, IF, ID, EX, MEM, WB).
//   req_if/id/ex/mem : per-stage stall requests
//   br_req/br_addr   : taken branch/jump resolved in EX
//   trap_req/addr    : exception/mret raised in MEM
//   stall, flush     : per-stage freeze / bubble, bit0=PC .. bit5=WB
//   isjump/jumpaddr  : PC loads jumpaddr at the next posedge
//   redir_busy       : a redirect is parked waiting for the PC to unfreeze
//   wdt_timeout      : sticky runaway-stall flag
//   state_dbg        : current FSM state
// Redirect handshake: a redirect is consumed by the PC in any cycle where
// isjump=1; isjump is only raised when stall[0]=0, so the PC is always
// able to accept it. A redirect arriving while stall[0]=1 is parked and
// re-issued in the first cycle with stall[0]=0.
module ysyx_22050058_pipe_ctrl
  import ysyx_22050058_pipe_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              TO_W     = 16,
  parameter logic [TO_W-1:0] TO_LIMIT = {TO_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_if,
  input  logic                  req_id,
  input  logic                  req_ex,
  input  logic                  req_mem,
  input  logic                  br_req,
  input  logic [ADDR_W-1:0]     br_addr,
  input  logic                  trap_req,
  input  logic [ADDR_W-1:0]     trap_addr,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  isjump,
  output logic [ADDR_W-1:0]     jumpaddr,
  output logic                  redir_busy,
  output logic                  wdt_timeout,
  output pipe_state_e           state_dbg
);

  pipe_state_e           state_q, state_d;
  logic [ADDR_W-1:0]     pend_addr_q, pend_addr_d;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] flush_c;
  logic                  isjump_c;
  logic [ADDR_W-1:0]     jumpaddr_c;
  logic                  stall_pc;
  logic [TO_W-1:0]       wdt_count;

  // Deepest requester wins; WB is never frozen.
  always_comb begin
    stall_raw = '0;
    if (req_mem)     stall_raw = stall_upto(STG_MEM);
    else if (req_ex) stall_raw = stall_upto(STG_EX);
    else if (req_id) stall_raw = stall_upto(STG_ID);
    else if (req_if) stall_raw = stall_upto(STG_IF);
  end

  assign stall    = rst ? stall_raw : '0;
  assign stall_pc = stall[STG_PC];

  // Redirect arbitration and parking FSM. Trap beats branch because the
  // trapping instruction in MEM is older than the branch in EX.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    flush_c     = '0;
    isjump_c    = 1'b0;
    jumpaddr_c  = '0;

    if (!stall_pc) begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_req) begin
            isjump_c   = 1'b1;
            jumpaddr_c = trap_addr;
            flush_c    = TRAP_FLUSH;
          end else if (br_req) begin
            isjump_c   = 1'b1;
            jumpaddr_c = br_addr;
            flush_c    = BR_FLUSH;
          end
        end
        ST_PEND_BR, ST_PEND_TRAP: begin
          // Release the parked redirect. The fetch made while frozen is on
          // the wrong path, so IF is always bubbled; a trap arriving in the
          // same cycle overrides the parked target and adds its own mask.
          isjump_c          = 1'b1;
          jumpaddr_c        = trap_req ? trap_addr : pend_addr_q;
          flush_c           = trap_req ? TRAP_FLUSH : '0;
          flush_c[STG_IF]   = 1'b1;
          state_d           = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_req) begin
            state_d     = ST_PEND_TRAP;
            pend_addr_d = trap_addr;
            flush_c     = TRAP_FLUSH;
          end else if (br_req) begin
            state_d     = ST_PEND_BR;
            pend_addr_d = br_addr;
            flush_c     = BR_FLUSH;
          end
        end
        ST_PEND_BR: begin
          // An older trap supersedes the parked branch.
          if (trap_req) begin
            state_d     = ST_PEND_TRAP;
            pend_addr_d = trap_addr;
            flush_c     = TRAP_FLUSH;
          end
        end
        ST_PEND_TRAP: begin
          // Anything younger than the parked trap is discarded.
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign flush      = rst ? flush_c    : '0;
  assign isjump     = rst ? isjump_c   : 1'b0;
  assign jumpaddr   = rst ? jumpaddr_c : '0;
  assign redir_busy = (state_q != ST_RUN);
  assign state_dbg  = state_q;

  ysyx_22050058_stall_wdt #(
    .TO_W     (TO_W),
    .TO_LIMIT (TO_LIMIT)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .stall_pc (stall_pc),
    .count_o  (wdt_count),
    .timeout  (wdt_timeout)
  );

  // The count is exposed for debug probing only.
  logic unused_count;
  assign unused_count = ^wdt_count;

endmodule

// File: tb/tb_ysyx_22050058_pipe_ctrl.sv
module tb_ysyx_22050058_pipe_ctrl;
  import ysyx_22050058_pipe_ctrl_pkg::*;

  localparam int AW = 64;
  localparam int EW = 6 + 6 + 1 + AW + 1 + 1;

  logic          clk;
  logic          rst;
  logic          req_if, req_id, req_ex, req_mem;
  logic          br_req, trap_req;
  logic [AW-1:0] br_addr, trap_addr;
  logic [5:0]    stall, flush;
  logic          isjump, redir_busy, wdt_timeout;
  logic [AW-1:0] jumpaddr;
  pipe_state_e   state_dbg;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            applied;
  int            miscompares;

  ysyx_22050058_pipe_ctrl #(
    .ADDR_W   (AW),
    .TO_W     (16),
    .TO_LIMIT (16'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (req_if),
    .req_id      (req_id),
    .req_ex      (req_ex),
    .req_mem     (req_mem),
    .br_req      (br_req),
    .br_addr     (br_addr),
    .trap_req    (trap_req),
    .trap_addr   (trap_addr),
    .stall       (stall),
    .flush       (flush),
    .isjump      (isjump),
    .jumpaddr    (jumpaddr),
    .redir_busy  (redir_busy),
    .wdt_timeout (wdt_timeout),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one vector per cycle, inputs applied just after the rising
  // edge, expected outputs for that cycle pushed to the scoreboard.
  // rq = {req_mem, req_ex, req_id, req_if}
  task automatic vec(input string nm, input logic r, input logic [3:0] rq,
                     input logic br, input logic [AW-1:0] ba,
                     input logic tr, input logic [AW-1:0] ta,
                     input logic [5:0] e_stall, input logic [5:0] e_flush,
                     input logic e_isj, input logic [AW-1:0] e_ja,
                     input logic e_busy, input logic e_wdt);
    @(posedge clk);
    #1;
    rst       = r;
    req_mem   = rq[3];
    req_ex    = rq[2];
    req_id    = rq[1];
    req_if    = rq[0];
    br_req    = br;
    br_addr   = ba;
    trap_req  = tr;
    trap_addr = ta;
    exp_q.push_back({e_stall, e_flush, e_isj, e_ja, e_busy, e_wdt});
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are combinational every cycle; compare on the
  // falling edge whenever a vector is outstanding.
  always @(negedge clk) begin
    logic [EW-1:0] exp_v, act_v;
    string         nm;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {stall, flush, isjump, jumpaddr, redir_busy, wdt_timeout};
      applied++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s: got stall=%b flush=%b isjump=%b jumpaddr=%h busy=%b wdt=%b, want stall=%b flush=%b isjump=%b jumpaddr=%h busy=%b wdt=%b",
                 nm, act_v[78:73], act_v[72:67], act_v[66], act_v[65:2], act_v[1], act_v[0],
                 exp_v[78:73], exp_v[72:67], exp_v[66], exp_v[65:2], exp_v[1], exp_v[0]);
      end
    end
    if (rst === 1'b1 && isjump === 1'b1 && stall[0] === 1'b1) begin
      miscompares++;
      $display("FAIL isjump_while_stalled: got isjump=1 stall0=1, want isjump=0");
    end
    if (rst === 1'b1 && state_dbg == ST_PEND_BR && br_req === 1'b1) begin
      miscompares++;
      $display("FAIL br_in_pend_br: got br_req=1 in PEND_BR, want no branch while parked");
    end
  end

  localparam logic [AW-1:0] Z = '0;

  initial begin
    applied     = 0;
    miscompares = 0;
    rst = 1'b0; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
    br_req = 0; trap_req = 0; br_addr = '0; trap_addr = '0;

    // Reset: everything forced low even with requests active
    vec("rst_forced", 0, 4'b1000, 1, 64'h8000_0040, 1, 64'h8000_0004, 6'b000000, 6'b000000, 0, Z, 0, 0);
    vec("rst_idle",   0, 4'b0000, 0, Z, 0, Z,                         6'b000000, 6'b000000, 0, Z, 0, 0);

    // 1: stall decode
    vec("t1_ex",      1, 4'b0100, 0, Z, 0, Z, 6'b001111, 6'b000000, 0, Z, 0, 0);
    vec("t1_ex_mem",  1, 4'b1100, 0, Z, 0, Z, 6'b011111, 6'b000000, 0, Z, 0, 0);
    vec("t1_id",      1, 4'b0010, 0, Z, 0, Z, 6'b000111, 6'b000000, 0, Z, 0, 0);
    vec("t1_idle",    1, 4'b0000, 0, Z, 0, Z, 6'b000000, 6'b000000, 0, Z, 0, 0);

    // 2: live branch
    vec("t2_br",      1, 4'b0000, 1, 64'h8000_0040, 0, Z, 6'b000000, 6'b000110, 1, 64'h8000_0040, 0, 0);
    vec("t2_after",   1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);

    // 3: branch parked behind IF stall
    vec("t3_c1",      1, 4'b0001, 1, 64'h8000_0100, 0, Z, 6'b000011, 6'b000110, 0, Z, 0, 0);
    vec("t3_c2",      1, 4'b0001, 0, Z, 0, Z,             6'b000011, 6'b000000, 0, Z, 1, 0);
    vec("t3_c3",      1, 4'b0001, 0, Z, 0, Z,             6'b000011, 6'b000000, 0, Z, 1, 0);
    vec("t3_release", 1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000010, 1, 64'h8000_0100, 1, 0);
    vec("t3_after",   1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);

    // 4: trap beats branch in the same cycle
    vec("t4_both",    1, 4'b0000, 1, 64'h8000_0200, 1, 64'h8000_0004, 6'b000000, 6'b011110, 1, 64'h8000_0004, 0, 0);
    vec("t4_after",   1, 4'b0000, 0, Z, 0, Z,                          6'b000000, 6'b000000, 0, Z, 0, 0);

    // 5: parked branch overridden by a live trap at unstall
    vec("t5_park",    1, 4'b0010, 1, 64'h8000_0200, 0, Z, 6'b000111, 6'b000110, 0, Z, 0, 0);
    vec("t5_hold",    1, 4'b0010, 0, Z, 0, Z,             6'b000111, 6'b000000, 0, Z, 1, 0);
    vec("t5_trap",    1, 4'b0000, 0, Z, 1, 64'h8000_0008, 6'b000000, 6'b011110, 1, 64'h8000_0008, 1, 0);
    vec("t5_run",     1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);

    // 5b: parked branch replaced by a parked trap; younger branch ignored
    vec("t5b_park",   1, 4'b0100, 1, 64'h8000_0300, 0, Z, 6'b001111, 6'b000110, 0, Z, 0, 0);
    vec("t5b_trap",   1, 4'b0100, 0, Z, 1, 64'h8000_0010, 6'b001111, 6'b011110, 0, Z, 1, 0);
    vec("t5b_br_ign", 1, 4'b0100, 1, 64'h8000_0400, 0, Z, 6'b001111, 6'b000000, 0, Z, 1, 0);
    vec("t5b_rel",    1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000010, 1, 64'h8000_0010, 1, 0);
    vec("t5b_run",    1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);

    // 6: watchdog with limit 4, then reset while a branch is parked
    for (int i = 0; i < 4; i++) begin
      vec($sformatf("t6_stall%0d", i), 1, 4'b0001, 0, Z, 0, Z, 6'b000011, 6'b000000, 0, Z, 0, 0);
    end
    vec("t6_limit",   1, 4'b0001, 0, Z, 0, Z,             6'b000011, 6'b000000, 0, Z, 0, 1);
    vec("t6_sticky1", 1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 1);
    vec("t6_sticky2", 1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 1);
    vec("t6_park",    1, 4'b1000, 1, 64'h8000_0500, 0, Z, 6'b011111, 6'b000110, 0, Z, 0, 1);
    vec("t6_rst",     0, 4'b1000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);
    vec("t6_release", 1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);
    vec("t6_quiet",   1, 4'b0000, 0, Z, 0, Z,             6'b000000, 6'b000000, 0, Z, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d outstanding vectors, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
